// File: rtl/video_pll_seq_pkg.sv
// Shared definitions for the video PLL retune sequencer.
//   seq_state_t     : sequencer FSM states
//   PARAM_* / TYPE_*: PLL reconfig cache address fields
//   GO_ADDR         : go / busy-status word address
//   ERR_*           : err_code values
package video_pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GO,
        ST_SETTLE,
        ST_POLL
    } seq_state_t;

    localparam logic [2:0] PARAM_N  = 3'd0;
    localparam logic [2:0] PARAM_M  = 3'd1;
    localparam logic [2:0] PARAM_C0 = 3'd4;

    localparam logic [3:0] TYPE_HIGH   = 4'd0;
    localparam logic [3:0] TYPE_LOW    = 4'd1;
    localparam logic [3:0] TYPE_BYPASS = 4'd4;
    localparam logic [3:0] TYPE_ODD    = 4'd5;

    localparam logic [7:0] GO_ADDR  = 8'h80;
    localparam logic [3:0] LAST_IDX = 4'd11;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ZERO_DIV = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    // Cache word address: bit 7 clear selects the parameter cache.
    function automatic logic [7:0] field_addr(input logic [2:0] param, input logic [3:0] ctype);
        return {1'b0, param, ctype};
    endfunction

endpackage

// File: rtl/video_pll_divider_split.sv
// Splits one PLL divider value into its counter fields.
//   v      : divider value (1..511)
//   high   : (v+1)>>1
//   low    : v - high
//   bypass : v == 1
//   odd    : v[0]
module video_pll_divider_split (
    input  logic [8:0] v,
    output logic [8:0] high,
    output logic [8:0] low,
    output logic       bypass,
    output logic       odd
);

    // (v+1)>>1 rewritten as v/2 + v[0]; same value, never overflows 9 bits.
    assign high   = {1'b0, v[8:1]} + {8'd0, v[0]};
    assign low    = v - high;
    assign bypass = (v == 9'd1);
    assign odd    = v[0];

endmodule

// File: rtl/video_pll_retune_sequencer.sv
// Avalon-MM master that retunes the video PLL from one (n, m, c0) request:
// writes 12 counter fields into the reconfig cache, hits go, waits a few
// cycles, then polls the busy word until it reads zero or times out.
//   csi_clk_clock / csi_clk_reset_n : clock, async active-low reset
//   req_valid/req_ready, req_n/m/c0 : retune request handshake
//   done, err, err_code             : completion / failure reporting
//   avm_*                           : Avalon-MM master to the reconfig slave
module video_pll_retune_sequencer
    import video_pll_seq_pkg::*;
#(
    parameter int POLL_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        csi_clk_clock,
    input  logic        csi_clk_reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [8:0]  req_n,
    input  logic [8:0]  req_m,
    input  logic [8:0]  req_c0,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  avm_address,
    output logic [31:0] avm_writedata,
    output logic        avm_write,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [16:0] TMO_LIM     = 17'(POLL_TIMEOUT);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    seq_state_t      state;
    logic [3:0]      idx;
    logic [7:0]      settle_cnt;
    logic [15:0]     tmo_cnt;
    logic [2:0][8:0] lat_div;   // 0 = n, 1 = m, 2 = c0

    logic [2:0][8:0] sp_high, sp_low;
    logic [2:0]      sp_byp, sp_odd;

    for (genvar g = 0; g < 3; g++) begin : g_split
        video_pll_divider_split u_split (
            .v      (lat_div[g]),
            .high   (sp_high[g]),
            .low    (sp_low[g]),
            .bypass (sp_byp[g]),
            .odd    (sp_odd[g])
        );
    end

    // idx[3:2] picks the divider, idx[1:0] picks the field within it.
    logic [1:0] dsel;
    logic [2:0] wr_param;
    logic [3:0] wr_type;
    logic [8:0] wr_field;

    always_comb begin
        dsel     = (idx[3:2] == 2'd3) ? 2'd2 : idx[3:2];
        wr_param = PARAM_C0;
        wr_type  = TYPE_ODD;
        wr_field = {8'd0, sp_odd[dsel]};
        case (dsel)
            2'd0:    wr_param = PARAM_N;
            2'd1:    wr_param = PARAM_M;
            default: wr_param = PARAM_C0;
        endcase
        case (idx[1:0])
            2'd0: begin wr_type = TYPE_HIGH;   wr_field = sp_high[dsel];         end
            2'd1: begin wr_type = TYPE_LOW;    wr_field = sp_low[dsel];          end
            2'd2: begin wr_type = TYPE_BYPASS; wr_field = {8'd0, sp_byp[dsel]};  end
            default: begin wr_type = TYPE_ODD; wr_field = {8'd0, sp_odd[dsel]};  end
        endcase
    end

    // Bus strobes decode straight from the state register so an async reset
    // drops write/read in the same instant, and everything holds by
    // construction while waitrequest stalls the state.
    assign req_ready = (state == ST_IDLE);
    assign avm_write = (state == ST_WRITE) || (state == ST_GO);
    assign avm_read  = (state == ST_POLL);

    always_comb begin
        avm_address   = 8'd0;
        avm_writedata = 32'd0;
        case (state)
            ST_WRITE: begin
                avm_address   = field_addr(wr_param, wr_type);
                avm_writedata = {23'd0, wr_field};
            end
            ST_GO, ST_POLL: avm_address = GO_ADDR;
            default: ;
        endcase
    end

    always_ff @(posedge csi_clk_clock or negedge csi_clk_reset_n) begin
        if (!csi_clk_reset_n) begin
            state      <= ST_IDLE;
            idx        <= 4'd0;
            settle_cnt <= 8'd0;
            tmo_cnt    <= 16'd0;
            lat_div    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_div <= {req_c0, req_m, req_n};
                        idx     <= 4'd0;
                        if (req_n == 9'd0 || req_m == 9'd0 || req_c0 == 9'd0) begin
                            err      <= 1'b1;
                            err_code <= ERR_ZERO_DIV;
                        end else begin
                            err_code <= ERR_NONE;
                            state    <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!avm_waitrequest) begin
                        if (idx == LAST_IDX) state <= ST_GO;
                        else                 idx   <= idx + 4'd1;
                    end
                end
                ST_GO: begin
                    if (!avm_waitrequest) begin
                        settle_cnt <= 8'd0;
                        tmo_cnt    <= 16'd0;
                        state      <= (SETTLE_CYCLES == 0) ? ST_POLL : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        tmo_cnt <= 16'd0;
                        state   <= ST_POLL;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_POLL: begin
                    if (!avm_waitrequest) begin
                        if (avm_readdata == 32'd0) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else if ({1'b0, tmo_cnt} + 17'd1 >= TMO_LIM) begin
                            err      <= 1'b1;
                            err_code <= ERR_TIMEOUT;
                            state    <= ST_IDLE;
                        end else if (tmo_cnt != 16'hFFFF) begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
